// File: rtl/pc_pkg.sv
// pc_pkg: shared next-PC select encoding and default widths for the fetch-stage PC unit
package pc_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int RESET_ADDR_DEF = 0;
  localparam int RAS_DEPTH_DEF = 4;
  typedef enum logic [2:0] {SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_CALL, SEL_RET, SEL_HOLD} pc_sel_e;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control flags in, PC and return-stack status out
interface pc_unit_if #(parameter int ADDR_W = pc_pkg::ADDR_W_DEF);
  logic stall, jump_flag, branch_flag, call_flag, ret_flag;
  logic [ADDR_W-1:0] jump_addr, branch_offset, PC_reg;
  logic ras_empty, ras_full, ras_err;
  modport master (
    output stall, jump_flag, branch_flag, call_flag, ret_flag, jump_addr, branch_offset,
    input PC_reg, ras_empty, ras_full, ras_err
  );
  modport slave (
    input stall, jump_flag, branch_flag, call_flag, ret_flag, jump_addr, branch_offset,
    output PC_reg, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/ras_stack.sv
// ras_stack: circular return-address LIFO that overwrites its oldest entry when pushed full
module ras_stack #(
  parameter int W = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;
  // ptr is the next free slot; when full it also indexes the oldest entry
  assign top = mem[ptr - PW'(1)];
  assign empty = cnt == '0;
  assign full = cnt == CW'(DEPTH);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else if (pop) begin
      if (empty) err <= 1'b1;
      else begin
        ptr <= ptr - PW'(1);
        cnt <= cnt - CW'(1);
      end
    end else if (push) begin
      ptr <= ptr + PW'(1);
      cnt <= full ? cnt : cnt + CW'(1);
      err <= err | full;
    end
  end
  always_ff @(posedge clk)
    if (push && !pop) mem[ptr] <= push_data;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with stall, jump, relative branch and call/return via a return stack
module pc_unit
  import pc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RESET_ADDR = RESET_ADDR_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input logic clk,
  input logic rst_n,
  pc_unit_if.slave bus
);
  pc_sel_e sel;
  logic [ADDR_W-1:0] pc, pc_inc, pc_next, ras_top;
  assign pc_inc = pc + ADDR_W'(1);
  always_comb begin
    sel = bus.stall ? SEL_HOLD : bus.ret_flag ? SEL_RET : bus.call_flag ? SEL_CALL :
          bus.jump_flag ? SEL_JUMP : bus.branch_flag ? SEL_BRANCH : SEL_SEQ;
    // a return with nothing stacked falls through to the next sequential address
    pc_next = sel == SEL_HOLD ? pc :
              sel == SEL_RET ? (bus.ras_empty ? pc_inc : ras_top) :
              (sel == SEL_CALL || sel == SEL_JUMP) ? bus.jump_addr :
              sel == SEL_BRANCH ? pc + bus.branch_offset : pc_inc;
  end
  always_ff @(posedge clk)
    pc <= !rst_n ? ADDR_W'(RESET_ADDR) : pc_next;
  assign bus.PC_reg = pc;
  ras_stack #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .rst_n(rst_n),
    .push(sel == SEL_CALL),
    .pop(sel == SEL_RET),
    .push_data(pc_inc),
    .top(ras_top),
    .empty(bus.ras_empty),
    .full(bus.ras_full),
    .err(bus.ras_err)
  );
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed plan plus random flags against a queue-based reference model
module tb_pc_unit;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [9:0] m_pc;
  logic [9:0] m_q[$];
  bit m_err;
  pc_unit_if #(.ADDR_W(10)) bus();
  pc_unit #(.ADDR_W(10), .RESET_ADDR(0), .RAS_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_step();
    if (!rst_n) begin
      m_pc = 10'd0;
      m_q.delete();
      m_err = 1'b0;
    end else if (bus.stall) begin
    end else if (bus.ret_flag) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin
        m_pc = m_pc + 10'd1;
        m_err = 1'b1;
      end
    end else if (bus.call_flag) begin
      if (m_q.size() == DEPTH) begin
        void'(m_q.pop_front());
        m_err = 1'b1;
      end
      m_q.push_back(m_pc + 10'd1);
      m_pc = bus.jump_addr;
    end else if (bus.jump_flag) m_pc = bus.jump_addr;
    else if (bus.branch_flag) m_pc = m_pc + bus.branch_offset;
    else m_pc = m_pc + 10'd1;
  endtask
  task automatic cycle(string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".pc"}, bus.PC_reg, m_pc);
    check({tag, ".empty"}, bus.ras_empty, m_q.size() == 0);
    check({tag, ".full"}, bus.ras_full, m_q.size() == DEPTH);
    check({tag, ".err"}, bus.ras_err, m_err);
  endtask
  task automatic clear();
    bus.stall = 0; bus.jump_flag = 0; bus.branch_flag = 0; bus.call_flag = 0; bus.ret_flag = 0;
    bus.jump_addr = '0; bus.branch_offset = '0;
  endtask
  task automatic act(string tag, bit j, bit b, bit c, bit r, logic [9:0] a, logic [9:0] off);
    bus.jump_flag = j; bus.branch_flag = b; bus.call_flag = c; bus.ret_flag = r;
    bus.jump_addr = a; bus.branch_offset = off;
    cycle(tag);
    clear();
  endtask
  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask
  initial begin
    clear();
    m_pc = 10'd0;
    m_err = 1'b0;
    idle("reset", 2);
    check("reset_pc", bus.PC_reg, 0);
    rst_n = 1'b1;
    idle("free", 5);
    check("free_pc5", bus.PC_reg, 5);
    act("jump", 1, 0, 0, 0, 10'd3, 0);
    check("jump_pc", bus.PC_reg, 3);
    idle("seq", 5);
    act("branch", 0, 1, 0, 0, 0, 10'h3FE);
    check("branch_pc", bus.PC_reg, 6);
    idle("seq", 4);
    act("call1", 0, 0, 1, 0, 10'd100, 0);
    check("call1_pc", bus.PC_reg, 100);
    idle("seq", 2);
    act("call2", 0, 0, 1, 0, 10'd200, 0);
    act("ret2", 0, 0, 0, 1, 0, 0);
    check("ret2_pc", bus.PC_reg, 103);
    act("ret1", 0, 0, 0, 1, 0, 0);
    check("ret1_pc", bus.PC_reg, 11);
    check("ret1_err", bus.ras_err, 0);
    for (int i = 0; i < 5; i++) act("nest", 0, 0, 1, 0, 10'(300 + 10 * i), 0);
    check("nest_full", bus.ras_full, 1);
    check("nest_err", bus.ras_err, 1);
    for (int i = 0; i < 4; i++) begin
      act("unwind", 0, 0, 0, 1, 0, 0);
      check("unwind_pc", bus.PC_reg, 10'(331 - 10 * i));
    end
    act("underflow", 0, 0, 0, 1, 0, 0);
    check("underflow_pc", bus.PC_reg, 302);
    act("prestall", 0, 0, 1, 0, 10'd400, 0);
    bus.stall = 1; bus.jump_flag = 1; bus.jump_addr = 10'd77;
    idle("stall", 3);
    check("stall_pc", bus.PC_reg, 400);
    clear();
    cycle("unstall");
    check("unstall_pc", bus.PC_reg, 401);
    act("tojmp", 1, 0, 0, 0, 10'h3FF, 0);
    cycle("wrap");
    check("wrap_pc", bus.PC_reg, 0);
    act("to49", 1, 0, 0, 0, 10'd49, 0);
    act("push50", 0, 0, 1, 0, 10'd500, 0);
    act("callret", 1, 0, 1, 1, 10'd600, 0);
    check("callret_pc", bus.PC_reg, 50);
    rst_n = 1'b0;
    act("rstcall", 0, 0, 1, 0, 10'd123, 0);
    check("rst_pc", bus.PC_reg, 0);
    check("rst_err", bus.ras_err, 0);
    rst_n = 1'b1;
    cycle("post_rst");
    check("post_rst_pc", bus.PC_reg, 1);
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 199) != 0;
      bus.stall = $urandom_range(0, 7) == 0;
      bus.ret_flag = $urandom_range(0, 4) == 0;
      bus.call_flag = $urandom_range(0, 4) == 0;
      bus.jump_flag = $urandom_range(0, 5) == 0;
      bus.branch_flag = $urandom_range(0, 5) == 0;
      bus.jump_addr = 10'($urandom);
      bus.branch_offset = 10'($urandom);
      cycle("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter for the pipelined core, replacing the fixed 10-bit jump-only counter. It drives the instruction ROM address each cycle and supports stall, absolute jump, PC-relative branch, and call/return through an internal circular return-address stack (RAS). It sits at the head of the fetch stage; its registered `PC_reg` also feeds the debug unit.

## Interface
- `ADDR_W`, 10: PC / ROM address width.
- `RESET_ADDR`, 0: PC value loaded on reset.
- `RAS_DEPTH`, 4: return-address stack entries; power of two, ≥2.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `stall`  in  1  hold PC and RAS unchanged this cycle.
- `jump_flag`  in  1  load `jump_addr`.
- `jump_addr`  in  ADDR_W  absolute target for jump and call.
- `branch_flag`  in  1  taken branch.
- `branch_offset`  in  ADDR_W  signed two's-complement offset, added to current PC.
- `call_flag`  in  1  push PC+1, load `jump_addr`.
- `ret_flag`  in  1  pop RAS into PC.
- `PC_reg`  out  ADDR_W  current program counter.
- `ras_empty`  out  1  RAS holds no entries.
- `ras_full`  out  1  RAS holds RAS_DEPTH entries.
- `ras_err`  out  1  sticky: underflow or overflow occurred since reset.

## Operation
- Next-PC priority, highest first: reset > stall > ret > call > jump > branch > sequential (PC+1).
- Reset: `PC_reg`=RESET_ADDR, RAS count=0, top pointer=0, `ras_empty`=1, `ras_full`=0, `ras_err`=0. RAS storage contents need no reset.
- Stall: every flag ignored, no state changes, including `ras_err`.
- Ret, RAS non-empty: PC ← top entry; count−1; pointer−1.
- Ret, RAS empty: PC ← PC+1; `ras_err` ← 1; count stays 0.
- Call: PC ← `jump_addr`; push PC+1. When full, overwrite oldest entry (circular); count stays RAS_DEPTH; `ras_err` ← 1.
- Ret and call in the same cycle: ret wins, call is dropped, no push.
- Jump: PC ← `jump_addr`. Branch: PC ← PC + `branch_offset`.
- All arithmetic is modulo 2^ADDR_W. PC+1 from all-ones wraps to 0, and the pushed return address wraps the same way. Branch overflow wraps silently.
- `ras_empty` and `ras_full` are decoded from the registered count.

## Timing
- One-cycle latency: flags sampled at edge N take effect in `PC_reg` after edge N. Flags are single-cycle pulses, one per intended action.
- `PC_reg` is a pure register output with no combinational path from inputs.
- Status outputs update on the same edge as the RAS change.
- Reset asserted mid-sequence overrides any flag on that edge. The first post-reset edge with all flags low gives RESET_ADDR+1.
- Stall held for K cycles: `PC_reg` is constant for K cycles, then resumes.

## Structure
- Shared package `pc_pkg`: next-PC select enum (SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_CALL, SEL_RET, SEL_HOLD) and default width constants.
- One sub-module, `ras_stack`: circular LIFO with count, push/pop, full/empty, overwrite-oldest on push when full. `pc_unit` holds the priority mux and the PC register.

## Test plan
- Reset, then 5 free-running cycles → `PC_reg` 0,1,2,3,4,5; `ras_empty`=1.
- At PC=5, `jump_flag`=1 with `jump_addr`=3 for one cycle → next PC 3, then 4. At PC=8, `branch_offset`=0x3FE (−2) → next PC 6.
- At PC=10, call to 100 → PC 100 (RAS top 11). Continue to 102, call to 200 → PC 200. Ret → 103, ret → 11, `ras_empty`=1, `ras_err`=0.
- RAS_DEPTH=4, five nested calls → `ras_full`=1, `ras_err`=1. Five rets return the four newest addresses in order, then the fifth ret underflows → PC+1.
- `stall` high for 3 cycles with `jump_flag`=1 → PC constant, RAS unchanged. Release stall → sequential increment.
- PC=0x3FF sequential → 0x000. Simultaneous call+ret with RAS top 50 → PC 50, no push. `rst_n`=0 mid-call → PC 0, RAS empty, `ras_err`=0.
